// File: rtl/mux_pkg.sv
// Shared defaults and source-enable strobe encodings for the mux block.
package mux_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  // Active-low strobes: the cleared bit marks the selected source.
  typedef enum logic [1:0] {
    AN_SEL_P = 2'b01,
    AN_SEL_I = 2'b10,
    AN_OFF   = 2'b11
  } an_e;

endpackage

// File: rtl/mux_sel_edge_det.sv
// Edge detector for the select line: delayed copy, registered any-edge pulse
// and a combinational rising-edge strobe for the period counter.
module sel_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sel,
  output logic sel_edge,
  output logic rise
);

  logic sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_d    <= 1'b0;
      sel_edge <= 1'b0;
    end else begin
      sel_d    <= sel;
      sel_edge <= sel ^ sel_d;
    end
  end

  // sel_d resets low, so a select held high through reset counts as a rise.
  assign rise = sel & ~sel_d;

endmodule

// File: rtl/mux.sv
// Two-source mux with registered copy, active-low source strobes and
// select-line transition tracking.
module mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_out,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] w_q,
  output logic [1:0]       an,
  output logic             sel_edge,
  output logic [CNT_W-1:0] phase_cnt
);

  an_e  an_q;
  logic rise;

  assign w  = clk_out ? p : i;
  assign an = an_q;

  sel_edge_det u_sel_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (clk_out),
    .sel_edge (sel_edge),
    .rise     (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= '0;
      an_q      <= AN_OFF;
      phase_cnt <= '0;
    end else begin
      w_q  <= w;
      an_q <= clk_out ? AN_SEL_P : AN_SEL_I;
      if (rise) begin
        phase_cnt <= phase_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux.sv
// Directed self-checking bench for the mux block.
module tb_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_out;
  logic [3:0] i;
  logic [3:0] p;
  logic [3:0] w;
  logic [3:0] w_q;
  logic [1:0] an;
  logic       sel_edge;
  logic [7:0] phase_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_cnt = 8'd0;

  mux #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_out   (clk_out),
    .i         (i),
    .p         (p),
    .w         (w),
    .w_q       (w_q),
    .an        (an),
    .sel_edge  (sel_edge),
    .phase_cnt (phase_cnt)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_out = 1'b0; i = 4'b0001; p = 4'b1000;
    tick(); tick();
    checks++; if (w_q !== 4'b0000) begin errors++; $display("FAIL reset_w_q: got %b want 0000", w_q); end
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_an: got %b want 11", an); end
    checks++; if (sel_edge !== 1'b0) begin errors++; $display("FAIL reset_sel_edge: got %b want 0", sel_edge); end
    checks++; if (phase_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", phase_cnt); end
    checks++; if (w !== 4'b0001) begin errors++; $display("FAIL reset_w: got %b want 0001", w); end
    rst_n = 1'b1;
  endtask

  task automatic test_select_i();
    tick();
    checks++; if (w !== 4'b0001) begin errors++; $display("FAIL sel_i_w: got %b want 0001", w); end
    checks++; if (w_q !== 4'b0001) begin errors++; $display("FAIL sel_i_w_q: got %b want 0001", w_q); end
    checks++; if (an !== 2'b10) begin errors++; $display("FAIL sel_i_an: got %b want 10", an); end
    checks++; if (sel_edge !== 1'b0) begin errors++; $display("FAIL sel_i_edge: got %b want 0", sel_edge); end
  endtask

  task automatic test_rise();
    clk_out = 1'b1;
    #1;
    checks++; if (w !== 4'b1000) begin errors++; $display("FAIL rise_w_now: got %b want 1000", w); end
    tick();
    exp_cnt++;
    checks++; if (sel_edge !== 1'b1) begin errors++; $display("FAIL rise_edge_on: got %b want 1", sel_edge); end
    checks++; if (phase_cnt !== exp_cnt) begin errors++; $display("FAIL rise_cnt: got %0d want %0d", phase_cnt, exp_cnt); end
    checks++; if (an !== 2'b01) begin errors++; $display("FAIL rise_an: got %b want 01", an); end
    checks++; if (w_q !== 4'b1000) begin errors++; $display("FAIL rise_w_q: got %b want 1000", w_q); end
    tick();
    checks++; if (sel_edge !== 1'b0) begin errors++; $display("FAIL rise_edge_off: got %b want 0", sel_edge); end
    checks++; if (phase_cnt !== exp_cnt) begin errors++; $display("FAIL rise_cnt_hold: got %0d want %0d", phase_cnt, exp_cnt); end
  endtask

  task automatic test_toggle();
    int unsigned pulses;
    logic [3:0]  exp_w;
    clk_out = 1'b0;
    tick(); tick(); tick();
    pulses = 0;
    for (int unsigned h = 0; h < 4; h++) begin
      clk_out = ~clk_out;
      if (clk_out) exp_cnt++;
      exp_w = clk_out ? 4'b1000 : 4'b0001;
      #1;
      checks++; if (w !== exp_w) begin errors++; $display("FAIL toggle_w[%0d]: got %b want %b", h, w, exp_w); end
      for (int unsigned c = 0; c < 10; c++) begin
        tick();
        if (sel_edge === 1'b1) pulses++;
      end
    end
    checks++; if (pulses != 4) begin errors++; $display("FAIL toggle_pulses: got %0d want 4", pulses); end
    checks++; if (phase_cnt !== exp_cnt) begin errors++; $display("FAIL toggle_cnt: got %0d want %0d", phase_cnt, exp_cnt); end
  endtask

  task automatic test_glitch();
    int unsigned pulses = 0;
    clk_out = 1'b1;
    #1;
    checks++; if (w !== 4'b1000) begin errors++; $display("FAIL glitch_w: got %b want 1000", w); end
    #2;
    clk_out = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      if (sel_edge === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
    checks++; if (phase_cnt !== exp_cnt) begin errors++; $display("FAIL glitch_cnt: got %0d want %0d", phase_cnt, exp_cnt); end
  endtask

  task automatic test_input_change();
    i = 4'b0110;
    #1;
    checks++; if (w !== 4'b0110) begin errors++; $display("FAIL inchg_w: got %b want 0110", w); end
    checks++; if (w_q !== 4'b0001) begin errors++; $display("FAIL inchg_w_q_before: got %b want 0001", w_q); end
    tick();
    checks++; if (w_q !== 4'b0110) begin errors++; $display("FAIL inchg_w_q_after: got %b want 0110", w_q); end
    checks++; if (sel_edge !== 1'b0) begin errors++; $display("FAIL inchg_edge: got %b want 0", sel_edge); end
    i = 4'b0001;
    tick();
  endtask

  task automatic test_async_reset();
    clk_out = 1'b1;
    exp_cnt++;
    tick(); tick(); tick();
    checks++; if (phase_cnt !== exp_cnt) begin errors++; $display("FAIL pre_reset_cnt: got %0d want %0d", phase_cnt, exp_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (w_q !== 4'b0000) begin errors++; $display("FAIL areset_w_q: got %b want 0000", w_q); end
    checks++; if (an !== 2'b11) begin errors++; $display("FAIL areset_an: got %b want 11", an); end
    checks++; if (phase_cnt !== 8'd0) begin errors++; $display("FAIL areset_cnt: got %0d want 0", phase_cnt); end
    checks++; if (w !== 4'b1000) begin errors++; $display("FAIL areset_w: got %b want 1000", w); end
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd1;
    tick();
    checks++; if (phase_cnt !== exp_cnt) begin errors++; $display("FAIL first_rise_cnt: got %0d want 1", phase_cnt); end
    checks++; if (sel_edge !== 1'b1) begin errors++; $display("FAIL first_rise_edge: got %b want 1", sel_edge); end
  endtask

  task automatic test_wrap();
    while (exp_cnt != 8'd255) begin
      clk_out = 1'b0; tick();
      clk_out = 1'b1; tick();
      exp_cnt++;
    end
    checks++; if (phase_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", phase_cnt); end
    clk_out = 1'b0; tick();
    clk_out = 1'b1; tick();
    checks++; if (phase_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", phase_cnt); end
  endtask

  initial begin
    test_reset();
    test_select_i();
    test_rise();
    test_toggle();
    test_glitch();
    test_input_change();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete, want completion within 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter WIDTH, default 4, data width of both inputs and both data outputs.
REQ-002 Parameter CNT_W, default 8, width of the select-period counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clk_out  input  1  select/phase line, 0 selects i, 1 selects p; slow toggling, synchronous to clk.
REQ-007 i  input  WIDTH  data source 0.
REQ-008 p  input  WIDTH  data source 1.
REQ-009 w  output  WIDTH  combinational mux result.
REQ-010 w_q  output  WIDTH  registered copy of w.
REQ-011 an  output  2  active-low source-enable strobes: an[0] low while i is selected, an[1] low while p is selected.
REQ-012 sel_edge  output  1  one-cycle pulse on any clk_out transition.
REQ-013 phase_cnt  output  CNT_W  count of clk_out rising transitions.

Function
REQ-014 w SHALL equal i when clk_out=0 and p when clk_out=1, purely combinational, zero latency, independent of clk and rst_n.
REQ-015 w_q SHALL load w on every rising clk edge (1-cycle latency).
REQ-016 an SHALL register clk_out ? 2'b01 : 2'b10 each clk edge; never both bits low.
REQ-017 An internal register sel_d SHALL hold clk_out delayed one clk cycle.
REQ-018 sel_edge SHALL be registered (clk_out XOR sel_d), asserting for exactly one cycle per transition, one cycle after the transition is sampled.
REQ-019 phase_cnt SHALL increment by 1 on each detected 0->1 transition of clk_out.
REQ-020 phase_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-021 A clk_out pulse shorter than one clk period that is not sampled high SHALL produce no edge and no count.
REQ-022 Input changes on i/p with clk_out static SHALL propagate to w immediately and to w_q next edge; no edge pulse.

Reset
REQ-023 While rst_n=0: w_q=0, an=2'b11, sel_edge=0, phase_cnt=0, sel_d=0.
REQ-024 Reset assertion SHALL take effect immediately, without a clock edge; release is synchronized to the next rising clk edge.
REQ-025 w SHALL keep following REQ-014 during reset.
REQ-026 First sampled clk_out=1 after reset SHALL count as a rising transition (sel_d reset to 0).

Structure
REQ-027 Package mux_pkg SHALL hold WIDTH and CNT_W defaults and the an encodings AN_SEL_I=2'b10, AN_SEL_P=2'b01, AN_OFF=2'b11.
REQ-028 Edge detection (sel_d, sel_edge, rise strobe) SHALL be one sub-module, sel_edge_det; the rest stays in mux.

Verification
REQ-029 i=0001, p=1000, clk_out=0 -> w=0001 immediately; w_q=0001 after 1 clk; an=10.
REQ-030 clk_out toggles 0->1 -> w=1000 same time step; sel_edge high exactly 1 cycle; phase_cnt +1; an=01.
REQ-031 clk_out toggling every 100 ns for 4 half-periods -> w alternates 0001/1000; phase_cnt=2; 4 sel_edge pulses.
REQ-032 rst_n low mid-operation with clk_out=1 -> w_q=0, an=11, phase_cnt=0 without a clock edge, w stays 1000.
REQ-033 phase_cnt=255 plus one more rising transition -> phase_cnt=0.
REQ-034 i changes 0001->0110 with clk_out=0 -> w=0110 immediately, w_q next edge, sel_edge stays 0.
